// File: rtl/mko_bus_resp_pkg.sv
// Shared types and helpers for the MKO bus responder: FSM states, widths, and the
// odd-parity check on the terminal address.
package mko_pkg;

    localparam int RDAT_W = 5;
    localparam int CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Odd parity over address plus parity bit: good when the XOR of all six bits is 1
    function automatic logic parity_ok(input logic [RDAT_W-1:0] rdat, input logic rdatp);
        return ^{rdat, rdatp};
    endfunction

endpackage

// File: rtl/mko_bus_resp_sync_edge.sv
// Two-flop synchroniser onto CLK_32 with single-cycle rise/fall pulses on the
// synchronised level. RST_VAL sets the idle level assumed during RESET.
module mko_sync_edge #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic CLK_32,
    input  logic RESET,
    input  logic d,
    output logic q,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge CLK_32) begin
        if (RESET) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= d;
            sync <= meta;
            prev <= sync;
        end
    end

    assign q    = sync;
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/mko_bus_resp.sv
// MKO host-interface device-side responder (1895VA2T bus-port emulation).
// Define MKO_RESP_TIMEOUT_EN to add the strobe-hold timeout and the timeout_o flag.
//
// state | meaning
// IDLE  | waiting for a selected strobe with a valid terminal address
// WAIT  | counting down WAIT_CYCLES before acknowledging
// ACK   | READYD_N low (read data driven) until the host releases the strobe
module mko_bus_resp
    import mko_pkg::*;
#(
    parameter int WB_DATA_WIDTH  = 16,
    parameter int REG_ADDR_W     = 3,
    parameter int WAIT_CYCLES    = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                     CLK_32,
    input  logic                     RESET,
    input  logic                     MKO_CLK,
    input  logic                     MKO_RES_N,
    input  logic                     MKO_STRBD_N,
    input  logic                     MKO_SELECT_N,
    input  logic                     MKO_RDWR_N,
    input  logic [RDAT_W-1:0]        MKO_RDAT,
    input  logic                     MKO_RDATP,
    input  logic [REG_ADDR_W-1:0]    MKO_ADDR,
    input  logic [WB_DATA_WIDTH-1:0] MKO_DAT_I,
    output logic [WB_DATA_WIDTH-1:0] MKO_DAT_O,
    output logic                     MKO_DAT_OE,
    output logic                     MKO_READYD_N,
    output logic [RDAT_W-1:0]        rt_addr_o,
    output logic                     rt_addr_valid,
    output logic                     parity_err,
`ifdef MKO_RESP_TIMEOUT_EN
    output logic                     timeout_o,
`endif
    output logic [CNT_W-1:0]         cycle_cnt
);

    localparam int          NWORDS    = 2 ** REG_ADDR_W;
    localparam logic [3:0]  WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic strb_s, strb_rise, strb_fall;
    logic sel_s,  sel_rise,  sel_fall;
    logic rdwr_s, rdwr_rise, rdwr_fall;
    logic res_s,  res_rise,  res_fall;
    logic mclk_s, mclk_rise, mclk_fall;

    mko_sync_edge #(.RST_VAL(1'b1)) u_sync_strb (
        .CLK_32(CLK_32), .RESET(RESET), .d(MKO_STRBD_N),
        .q(strb_s), .rise(strb_rise), .fall(strb_fall)
    );
    mko_sync_edge #(.RST_VAL(1'b1)) u_sync_sel (
        .CLK_32(CLK_32), .RESET(RESET), .d(MKO_SELECT_N),
        .q(sel_s), .rise(sel_rise), .fall(sel_fall)
    );
    mko_sync_edge #(.RST_VAL(1'b1)) u_sync_rdwr (
        .CLK_32(CLK_32), .RESET(RESET), .d(MKO_RDWR_N),
        .q(rdwr_s), .rise(rdwr_rise), .fall(rdwr_fall)
    );
    // Starting low means a host that already released RES_N is latched after RESET
    mko_sync_edge #(.RST_VAL(1'b0)) u_sync_res (
        .CLK_32(CLK_32), .RESET(RESET), .d(MKO_RES_N),
        .q(res_s), .rise(res_rise), .fall(res_fall)
    );
    mko_sync_edge #(.RST_VAL(1'b0)) u_sync_mclk (
        .CLK_32(CLK_32), .RESET(RESET), .d(MKO_CLK),
        .q(mclk_s), .rise(mclk_rise), .fall(mclk_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{strb_rise, sel_rise, sel_fall, rdwr_rise, rdwr_fall,
                           res_fall, mclk_s, mclk_rise, mclk_fall};

    state_t                    state;
    logic [3:0]                wait_cnt;
    logic                      lat_rd;
    logic [REG_ADDR_W-1:0]     lat_addr;
    logic [WB_DATA_WIDTH-1:0]  lat_data;
    logic [WB_DATA_WIDTH-1:0]  regs [NWORDS];

`ifdef MKO_RESP_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] to_cnt;
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

    always_ff @(posedge CLK_32) begin
        if (RESET) begin
            state         <= IDLE;
            wait_cnt      <= '0;
            lat_rd        <= 1'b1;
            lat_addr      <= '0;
            lat_data      <= '0;
            MKO_DAT_O     <= '0;
            MKO_DAT_OE    <= 1'b0;
            MKO_READYD_N  <= 1'b1;
            rt_addr_o     <= '0;
            rt_addr_valid <= 1'b0;
            parity_err    <= 1'b0;
            cycle_cnt     <= '0;
            for (int i = 0; i < NWORDS; i++) regs[i] <= '0;
`ifdef MKO_RESP_TIMEOUT_EN
            to_cnt        <= '0;
            timeout_o     <= 1'b0;
`endif
        end else if (!res_s) begin
            // Device reset overrides any cycle in flight, including a pending write
            state         <= IDLE;
            MKO_READYD_N  <= 1'b1;
            MKO_DAT_OE    <= 1'b0;
            rt_addr_valid <= 1'b0;
            for (int i = 0; i < NWORDS; i++) regs[i] <= '0;
`ifdef MKO_RESP_TIMEOUT_EN
            timeout_o     <= 1'b0;
`endif
        end else begin
            if (res_rise) begin
                rt_addr_o     <= MKO_RDAT;
                rt_addr_valid <= parity_ok(MKO_RDAT, MKO_RDATP);
                parity_err    <= ~parity_ok(MKO_RDAT, MKO_RDATP);
            end

            case (state)
                IDLE: begin
                    if (strb_fall && !sel_s && rt_addr_valid) begin
                        state    <= WAIT;
                        lat_rd   <= rdwr_s;
                        lat_addr <= MKO_ADDR;
                        lat_data <= MKO_DAT_I;
                        wait_cnt <= WAIT_LOAD;
`ifdef MKO_RESP_TIMEOUT_EN
                        to_cnt   <= TO_LOAD;
`endif
                    end
                end

                WAIT: begin
`ifdef MKO_RESP_TIMEOUT_EN
                    to_cnt <= to_cnt - 1'b1;
                    if (to_cnt == '0) begin
                        state     <= IDLE;
                        timeout_o <= 1'b1;
                    end else
`endif
                    if (strb_s) begin
                        state <= IDLE;
                    end else if (wait_cnt == '0) begin
                        state        <= ACK;
                        MKO_READYD_N <= 1'b0;
                        cycle_cnt    <= cycle_cnt + 1'b1;
                        if (lat_rd) begin
                            MKO_DAT_O  <= regs[lat_addr];
                            MKO_DAT_OE <= 1'b1;
                        end else begin
                            regs[lat_addr] <= lat_data;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                ACK: begin
`ifdef MKO_RESP_TIMEOUT_EN
                    to_cnt <= to_cnt - 1'b1;
                    if (to_cnt == '0) begin
                        state        <= IDLE;
                        MKO_READYD_N <= 1'b1;
                        MKO_DAT_OE   <= 1'b0;
                        timeout_o    <= 1'b1;
                    end else
`endif
                    if (strb_s) begin
                        state        <= IDLE;
                        MKO_READYD_N <= 1'b1;
                        MKO_DAT_OE   <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mko_bus_resp.sv
// Scoreboard bench for mko_bus_resp: directed address/reset scenarios plus random
// read/write traffic checked against an array model of the register file.
`timescale 1ns/1ps
module tb_mko_bus_resp;

    localparam int DW = 16;
    localparam int AW = 3;
    localparam int WAIT_CYCLES = 4;
    localparam int TIMEOUT_CYCLES = 64;

    logic          CLK_32 = 1'b0;
    logic          RESET;
    logic          MKO_CLK = 1'b0;
    logic          MKO_RES_N;
    logic          MKO_STRBD_N;
    logic          MKO_SELECT_N;
    logic          MKO_RDWR_N;
    logic [4:0]    MKO_RDAT;
    logic          MKO_RDATP;
    logic [AW-1:0] MKO_ADDR;
    logic [DW-1:0] MKO_DAT_I;
    logic [DW-1:0] MKO_DAT_O;
    logic          MKO_DAT_OE;
    logic          MKO_READYD_N;
    logic [4:0]    rt_addr_o;
    logic          rt_addr_valid;
    logic          parity_err;
    logic [15:0]   cycle_cnt;
`ifdef MKO_RESP_TIMEOUT_EN
    logic          timeout_o;
`endif

    mko_bus_resp #(
        .WB_DATA_WIDTH(DW), .REG_ADDR_W(AW),
        .WAIT_CYCLES(WAIT_CYCLES), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) dut (
        .CLK_32(CLK_32), .RESET(RESET), .MKO_CLK(MKO_CLK), .MKO_RES_N(MKO_RES_N),
        .MKO_STRBD_N(MKO_STRBD_N), .MKO_SELECT_N(MKO_SELECT_N), .MKO_RDWR_N(MKO_RDWR_N),
        .MKO_RDAT(MKO_RDAT), .MKO_RDATP(MKO_RDATP), .MKO_ADDR(MKO_ADDR),
        .MKO_DAT_I(MKO_DAT_I), .MKO_DAT_O(MKO_DAT_O), .MKO_DAT_OE(MKO_DAT_OE),
        .MKO_READYD_N(MKO_READYD_N), .rt_addr_o(rt_addr_o), .rt_addr_valid(rt_addr_valid),
        .parity_err(parity_err),
`ifdef MKO_RESP_TIMEOUT_EN
        .timeout_o(timeout_o),
`endif
        .cycle_cnt(cycle_cnt)
    );

    always #15 CLK_32 = ~CLK_32;
    always #30 MKO_CLK = ~MKO_CLK;

    typedef struct {
        int          fall_cyc;
        logic        rd;
        logic [15:0] data;
        logic [15:0] cnt;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    logic        prev_rdy = 1'b1;

    logic [15:0] model_mem [8];
    logic [15:0] model_cnt;
    logic        model_valid;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge CLK_32) cyc++;

    // Monitor: every falling READYD_N must match the oldest expected acknowledge
    always @(negedge CLK_32) begin
        if (MKO_READYD_N === 1'b0 && prev_rdy === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_ack: got READYD_N=0 expected no acknowledge (cycle %0d)", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                check("ack_latency", 32'(cyc - mon_e.fall_cyc), 32'(3 + WAIT_CYCLES));
                check("ack_oe", {31'd0, MKO_DAT_OE}, {31'd0, mon_e.rd});
                if (mon_e.rd) check("read_data", {16'd0, MKO_DAT_O}, {16'd0, mon_e.data});
                check("cycle_cnt", {16'd0, cycle_cnt}, {16'd0, mon_e.cnt});
            end
        end
        prev_rdy = MKO_READYD_N;
    end

    task automatic model_clear();
        for (int i = 0; i < 8; i++) model_mem[i] = '0;
        model_valid = 1'b0;
    endtask

    // Pulse RES_N low, present an address, release, and check the latched result
    task automatic do_res(input logic [4:0] rdat, input logic p);
        @(negedge CLK_32);
        MKO_RES_N = 1'b0;
        model_clear();
        repeat (4) @(negedge CLK_32);
        check("valid_in_reset", {31'd0, rt_addr_valid}, 32'd0);
        MKO_RDAT  = rdat;
        MKO_RDATP = p;
        @(negedge CLK_32);
        MKO_RES_N = 1'b1;
        repeat (5) @(negedge CLK_32);
        model_valid = ($countones({rdat, p}) % 2) == 1;
        check("rt_addr", {27'd0, rt_addr_o}, {27'd0, rdat});
        check("rt_addr_valid", {31'd0, rt_addr_valid}, {31'd0, model_valid});
        check("parity_err", {31'd0, parity_err}, {31'd0, !model_valid});
    endtask

    task automatic host_cycle(input logic rd, input logic [2:0] addr,
                              input logic [15:0] data, input logic sel);
        logic ack;
        exp_t e;
        int   i;
        ack = model_valid && sel;
        @(negedge CLK_32);
        MKO_RDWR_N   = rd;
        MKO_ADDR     = addr;
        MKO_DAT_I    = data;
        MKO_SELECT_N = !sel;
        @(negedge CLK_32);
        MKO_STRBD_N = 1'b0;
        if (ack) begin
            e.fall_cyc = cyc;
            e.rd       = rd;
            e.data     = model_mem[addr];
            model_cnt  = model_cnt + 16'd1;
            e.cnt      = model_cnt;
            exp_q.push_back(e);
            if (!rd) model_mem[addr] = data;
            for (i = 0; i < WAIT_CYCLES + 12 && MKO_READYD_N !== 1'b0; i++) @(negedge CLK_32);
            check("ack_seen", {31'd0, MKO_READYD_N}, 32'd0);
        end else begin
            repeat (WAIT_CYCLES + 8) @(negedge CLK_32);
            check("no_ack_cnt", {16'd0, cycle_cnt}, {16'd0, model_cnt});
        end
        MKO_STRBD_N = 1'b1;
        repeat (4) @(negedge CLK_32);
        check("rdy_release", {31'd0, MKO_READYD_N}, 32'd1);
        check("oe_release", {31'd0, MKO_DAT_OE}, 32'd0);
        MKO_SELECT_N = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion expected finish before 500us");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET        = 1'b1;
        MKO_RES_N    = 1'b0;
        MKO_STRBD_N  = 1'b1;
        MKO_SELECT_N = 1'b1;
        MKO_RDWR_N   = 1'b1;
        MKO_RDAT     = '0;
        MKO_RDATP    = 1'b0;
        MKO_ADDR     = '0;
        MKO_DAT_I    = '0;
        model_clear();
        model_cnt = '0;
        repeat (5) @(negedge CLK_32);
        RESET = 1'b0;
        @(negedge CLK_32);
        check("rst_readyd", {31'd0, MKO_READYD_N}, 32'd1);
        check("rst_oe", {31'd0, MKO_DAT_OE}, 32'd0);
        check("rst_dat_o", {16'd0, MKO_DAT_O}, 32'd0);
        check("rst_rt_addr", {27'd0, rt_addr_o}, 32'd0);
        check("rst_valid", {31'd0, rt_addr_valid}, 32'd0);
        check("rst_perr", {31'd0, parity_err}, 32'd0);
        check("rst_cnt", {16'd0, cycle_cnt}, 32'd0);

        // Bad parity: strobes must be ignored
        do_res(5'b00011, 1'b0);
        host_cycle(1'b0, 3'd1, 16'h1111, 1'b1);

        // Good parity, write then read back
        do_res(5'b00011, 1'b1);
        host_cycle(1'b0, 3'd2, 16'hA5C3, 1'b1);
        host_cycle(1'b1, 3'd2, 16'h0000, 1'b1);
        check("cnt_after_wr_rd", {16'd0, cycle_cnt}, 32'd2);

        // Strobe without select
        host_cycle(1'b0, 3'd3, 16'hBEEF, 1'b0);

        // Short strobe aborts the write in WAIT
        @(negedge CLK_32);
        MKO_RDWR_N = 1'b0; MKO_ADDR = 3'd5; MKO_DAT_I = 16'hDEAD; MKO_SELECT_N = 1'b0;
        @(negedge CLK_32);
        MKO_STRBD_N = 1'b0;
        repeat (2) @(negedge CLK_32);
        MKO_STRBD_N = 1'b1;
        repeat (10) @(negedge CLK_32);
        MKO_SELECT_N = 1'b1;
        check("abort_cnt", {16'd0, cycle_cnt}, {16'd0, model_cnt});
        host_cycle(1'b1, 3'd5, 16'h0000, 1'b1);

        // Seed addr 5 then drop RES_N during WAIT of a second write to it
        host_cycle(1'b0, 3'd5, 16'h7E57, 1'b1);
        @(negedge CLK_32);
        MKO_RDWR_N = 1'b0; MKO_ADDR = 3'd5; MKO_DAT_I = 16'h1234; MKO_SELECT_N = 1'b0;
        @(negedge CLK_32);
        MKO_STRBD_N = 1'b0;
        repeat (2) @(negedge CLK_32);
        MKO_RES_N = 1'b0;
        model_clear();
        repeat (8) @(negedge CLK_32);
        check("resmid_readyd", {31'd0, MKO_READYD_N}, 32'd1);
        check("resmid_cnt", {16'd0, cycle_cnt}, {16'd0, model_cnt});
        check("resmid_valid", {31'd0, rt_addr_valid}, 32'd0);
        MKO_STRBD_N  = 1'b1;
        MKO_SELECT_N = 1'b1;
        do_res(5'b10110, 1'b0);
        host_cycle(1'b1, 3'd5, 16'h0000, 1'b1);

        // Random traffic
        for (int k = 0; k < 60; k++) begin
            host_cycle(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                       16'($urandom), $urandom_range(0, 9) != 0);
        end
        for (int a = 0; a < 8; a++) host_cycle(1'b1, 3'(a), 16'h0000, 1'b1);

`ifdef MKO_RESP_TIMEOUT_EN
        @(negedge CLK_32);
        MKO_RDWR_N = 1'b1; MKO_ADDR = 3'd0; MKO_SELECT_N = 1'b0;
        @(negedge CLK_32);
        MKO_STRBD_N = 1'b0;
        begin
            exp_t te;
            te.fall_cyc = cyc;
            te.rd       = 1'b1;
            te.data     = model_mem[0];
            model_cnt   = model_cnt + 16'd1;
            te.cnt      = model_cnt;
            exp_q.push_back(te);
        end
        repeat (100) @(negedge CLK_32);
        check("timeout_readyd", {31'd0, MKO_READYD_N}, 32'd1);
        check("timeout_oe", {31'd0, MKO_DAT_OE}, 32'd0);
        check("timeout_flag", {31'd0, timeout_o}, 32'd1);
        MKO_STRBD_N = 1'b1;
        repeat (4) @(negedge CLK_32);
        MKO_SELECT_N = 1'b1;
`endif

        repeat (5) @(negedge CLK_32);
        check("pending_acks", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
